neuron_spike_arbiter: RTL and testbench

Clocked front-end that shares one asynchronous spiking-neuron control/datapath between N_REQ synchronous spike sources. It runs a round-robin arbiter and drives the neuron input channel (4-phase req/ack) with the granted source's weight. It also acknowledges the neuron output channel (4-phase), converts each output spike into a one-cycle pulse and counts the spikes. It sits between the clocked spike-routing fabric and the neuron's req_in/ack_in and req_out/ack_out ports.

---
 rtl/neuron_spike_arbiter.sv | 176 +++++++++++++++++
 tb/tb_neuron_spike_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_spike_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : neuron_spike_arbiter
// Brief    : Round-robin front-end sharing one async spiking neuron between
//            N_REQ clocked sources; acks/counts the neuron's output spikes.
//            Optional 2-flop input synchronizers: NEURON_ARB_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_spike_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W_WIDTH   = 8,
    parameter int CNT_WIDTH = 16,
    localparam int GW       = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         src_req,
    input  logic [N_REQ*W_WIDTH-1:0] src_weight,
    output logic [N_REQ-1:0]         src_ack,
    output logic                     n_req_in,
    input  logic                     n_ack_in,
    output logic [W_WIDTH-1:0]       n_weight,
    input  logic                     n_req_out,
    output logic                     n_ack_out,
    output logic                     busy,
    output logic [GW-1:0]            grant_idx,
    output logic                     spike_out,
    output logic [CNT_WIDTH-1:0]     spike_cnt
);

    localparam logic [GW-1:0]        c_LAST    = GW'(N_REQ - 1);
    localparam logic [GW:0]          c_NREQ    = (GW + 1)'(N_REQ);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {ARB = 2'd0, RISE = 2'd1, FALL = 2'd2} in_state_t;
    typedef enum logic [0:0] {O_IDLE = 1'b0, O_ACK = 1'b1} out_state_t;

    in_state_t            r_in_state;
    out_state_t           r_out_state;
    logic [GW-1:0]        r_ptr;
    logic [GW-1:0]        r_grant;
    logic [N_REQ-1:0]     r_src_ack;
    logic                 r_req_in;
    logic [W_WIDTH-1:0]   r_weight;
    logic                 r_busy;
    logic                 r_ack_out;
    logic                 r_spike;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_ack_s;
    logic                 w_reqo_s;
    logic [N_REQ-1:0]     w_eligible;
    logic [GW:0]          w_idx;
    logic [GW-1:0]        w_pick;
    logic                 w_found;

`ifdef NEURON_ARB_SYNC_EN
    logic [1:0] r_ack_sync;
    logic [1:0] r_reqo_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_sync  <= 2'b00;
            r_reqo_sync <= 2'b00;
        end else begin
            r_ack_sync  <= {r_ack_sync[0], n_ack_in};
            r_reqo_sync <= {r_reqo_sync[0], n_req_out};
        end
    end

    assign w_ack_s  = r_ack_sync[1];
    assign w_reqo_s = r_reqo_sync[1];
`else
    assign w_ack_s  = n_ack_in;
    assign w_reqo_s = n_req_out;
`endif

    // A source completing this cycle is masked so others get a turn first.
    always_comb begin
        w_eligible = src_req & ~r_src_ack;
        w_found    = 1'b0;
        w_pick     = '0;
        w_idx      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (GW + 1)'(k);
            if (w_idx >= c_NREQ) begin
                w_idx = w_idx - c_NREQ;
            end
            if (!w_found && w_eligible[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state <= ARB;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_src_ack  <= '0;
            r_req_in   <= 1'b0;
            r_weight   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_src_ack <= '0;
            case (r_in_state)
                ARB: begin
                    if (w_found) begin
                        r_in_state <= RISE;
                        r_req_in   <= 1'b1;
                        r_weight   <= src_weight[w_pick*W_WIDTH +: W_WIDTH];
                        r_grant    <= w_pick;
                        r_busy     <= 1'b1;
                    end
                end
                RISE: begin
                    if (w_ack_s) begin
                        r_in_state <= FALL;
                        r_req_in   <= 1'b0;
                    end
                end
                FALL: begin
                    if (!w_ack_s) begin
                        r_in_state         <= ARB;
                        r_src_ack[r_grant] <= 1'b1;
                        r_ptr              <= (r_grant == c_LAST) ? '0 : r_grant + 1'b1;
                        r_busy             <= 1'b0;
                    end
                end
                default: r_in_state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_state <= O_IDLE;
            r_ack_out   <= 1'b0;
            r_spike     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_spike <= 1'b0;
            case (r_out_state)
                O_IDLE: begin
                    if (w_reqo_s) begin
                        r_out_state <= O_ACK;
                        r_ack_out   <= 1'b1;
                        r_spike     <= 1'b1;
                        if (r_cnt != c_CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                O_ACK: begin
                    if (!w_reqo_s) begin
                        r_out_state <= O_IDLE;
                        r_ack_out   <= 1'b0;
                    end
                end
                default: r_out_state <= O_IDLE;
            endcase
        end
    end

    assign src_ack   = r_src_ack;
    assign n_req_in  = r_req_in;
    assign n_weight  = r_weight;
    assign busy      = r_busy;
    assign grant_idx = r_grant;
    assign n_ack_out = r_ack_out;
    assign spike_out = r_spike;
    assign spike_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_neuron_spike_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_spike_arbiter
// Brief    : Directed + randomized bench for neuron_spike_arbiter with a
//            transaction-level round-robin / spike-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_spike_arbiter;

`ifdef NEURON_ARB_SYNC_EN
    localparam int c_SYNC = 2;
`else
    localparam int c_SYNC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src_req = 4'b1111;
    logic [31:0] src_weight = 32'h44_33_22_11;
    logic        n_ack_in = 1'b0;
    logic        n_req_out = 1'b0;

    logic [3:0]  src_ack;
    logic        n_req_in;
    logic [7:0]  n_weight;
    logic        n_ack_out;
    logic        busy;
    logic [1:0]  grant_idx;
    logic        spike_out;
    logic [15:0] spike_cnt;

    logic [3:0]  d2_src_ack;
    logic        d2_n_req_in;
    logic [7:0]  d2_n_weight;
    logic        d2_n_ack_out;
    logic        d2_busy;
    logic [1:0]  d2_grant_idx;
    logic        d2_spike_out;
    logic [1:0]  d2_spike_cnt;

    neuron_spike_arbiter #(.N_REQ(4), .W_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_weight(src_weight),
        .src_ack(src_ack), .n_req_in(n_req_in), .n_ack_in(n_ack_in),
        .n_weight(n_weight), .n_req_out(n_req_out), .n_ack_out(n_ack_out),
        .busy(busy), .grant_idx(grant_idx), .spike_out(spike_out),
        .spike_cnt(spike_cnt)
    );

    neuron_spike_arbiter #(.N_REQ(4), .W_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .src_req(src_req), .src_weight(src_weight),
        .src_ack(d2_src_ack), .n_req_in(d2_n_req_in), .n_ack_in(n_ack_in),
        .n_weight(d2_n_weight), .n_req_out(n_req_out), .n_ack_out(d2_n_ack_out),
        .busy(d2_busy), .grant_idx(d2_grant_idx), .spike_out(d2_spike_out),
        .spike_cnt(d2_spike_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input int p, input logic [3:0] e);
        for (int k = 0; k < 4; k++) begin
            if (e[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Neuron input channel: mirrors n_req_in onto n_ack_in after in_delay cycles.
    int in_delay = 1;
    int nd_cnt = 0;
    always @(negedge clk) begin
        if (n_req_in !== n_ack_in) begin
            nd_cnt++;
            if (nd_cnt >= in_delay) begin
                n_ack_in = n_req_in;
                nd_cnt   = 0;
            end
        end else begin
            nd_cnt = 0;
        end
    end

    // Reference model, evaluated just after each rising edge.
    bit         m_busy = 0;
    int         m_ptr = 0, m_g = 0, m_age = 0;
    logic [7:0] m_w = '0;
    logic [3:0] prev_ack = '0;
    logic       prev_nack = 1'b0;
    int         m_cnt = 0, m_cnt2 = 0, m_spk = 0;
    int         ack_cnt [4];
    int         grant_q [$];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_ctrl", {src_ack, n_req_in, n_ack_out, busy, grant_idx, spike_out}, 0);
            chk("rst_weight", n_weight, 0);
            chk("rst_cnt", spike_cnt, 0);
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_cnt2 = 0; m_spk = 0;
            prev_ack = '0; prev_nack = 1'b0;
            for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
            grant_q.delete();
        end else begin
            if (!m_busy) begin
                logic [3:0] elig;
                elig = src_req & ~prev_ack;
                chk("idle_ack", src_ack, 0);
                if (elig != 0) begin
                    m_g = rr(m_ptr, elig);
                    m_w = src_weight[m_g*8 +: 8];
                    chk("grant_req", n_req_in, 1);
                    chk("grant_idx", grant_idx, m_g);
                    chk("grant_weight", n_weight, m_w);
                    chk("grant_busy", busy, 1);
                    m_busy = 1; m_age = 0;
                    grant_q.push_back(m_g);
                end else begin
                    chk("idle_req", n_req_in, 0);
                    chk("idle_busy", busy, 0);
                end
            end else begin
                chk("hold_weight", n_weight, m_w);
                chk("hold_idx", grant_idx, m_g);
                if (src_ack != 0) begin
                    chk("ack_onehot", src_ack, 1 << m_g);
                    chk("ack_busy", busy, 0);
                    ack_cnt[m_g]++;
                    m_ptr  = (m_g + 1) % 4;
                    m_busy = 0;
                end else begin
                    chk("hold_busy", busy, 1);
                    m_age++;
                    chk("txn_age_ok", m_age <= 200, 1);
                end
            end
            chk("spike_pulse", spike_out, n_ack_out && !prev_nack);
            if (spike_out) begin
                m_spk++;
                m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            chk("spike_cnt", spike_cnt, m_cnt);
            chk("sat_cnt", d2_spike_cnt, m_cnt2);
            prev_ack  = src_ack;
            prev_nack = n_ack_out;
        end
    end

    function automatic int ack_total();
        return ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
    endfunction

    task automatic wait_ack(input int i, input string tag);
        int t = 0;
        while (!src_ack[i] && t < 400) begin @(negedge clk); t++; end
        chk(tag, src_ack[i], 1);
    endtask

    task automatic wait_reqin(input string tag);
        int t = 0;
        while (!n_req_in && t < 400) begin @(negedge clk); t++; end
        chk(tag, n_req_in, 1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic spike(output int lat);
        int t = 0;
        n_req_out = 1'b1;
        while (!n_ack_out && t < 50) begin @(negedge clk); t++; end
        lat = t;
        n_req_out = 1'b0;
        t = 0;
        while (n_ack_out && t < 50) begin @(negedge clk); t++; end
        chk("spike_release", n_ack_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, lat, raises;

        // Reset with every source requesting, then first grant.
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_req_in", n_req_in, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req_in", n_req_in, 1);
        chk("first_idx", grant_idx, 0);
        t = 0;
        while (n_req_in && t < 50) begin @(negedge clk); t++; end
        chk("fall_latency", t, 1 + c_SYNC);
        while (src_ack == 0 && t < 50) begin @(negedge clk); t++; end
        chk("txn_latency", t, 2 + 2 * c_SYNC);

        // All four requesting for eight transactions.
        t = 0;
        while (ack_total() < 8 && t < 400) begin @(negedge clk); t++; end
        src_req = 4'b0000;
        chk("order_len", grant_q.size() >= 8, 1);
        for (int i = 0; i < 8 && i < grant_q.size(); i++) chk("rr_order", grant_q[i], i % 4);
        t = 0;
        while (busy && t < 100) begin @(negedge clk); t++; end

        // Single source 2 with a slower neuron.
        do_reset();
        src_weight[16 +: 8] = 8'h5A;
        in_delay = 3;
        @(negedge clk);
        src_req = 4'b0100;
        wait_ack(2, "single_ack");
        chk("single_weight", n_weight, 8'h5A);
        src_req[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("single_ack_once", ack_cnt[2], 1);
        chk("single_busy_off", busy, 0);
        src_req = 4'b1001;
        wait_reqin("ptr_grant");
        chk("ptr_after_2", grant_idx, 3);
        wait_ack(3, "ptr_ack3");
        src_req[3] = 1'b0;
        wait_ack(0, "ptr_ack0");
        src_req[0] = 1'b0;

        // Lone persistent source 1: masked in its ack cycle only.
        in_delay = 1;
        @(negedge clk);
        src_req = 4'b0010;
        wait_ack(1, "persist_ack");
        @(negedge clk);
        chk("no_regrant", n_req_in, 0);
        @(negedge clk);
        chk("regrant_req", n_req_in, 1);
        chk("regrant_idx", grant_idx, 1);
        wait_ack(1, "persist_ack2");
        src_req[1] = 1'b0;

        // Output spikes while an input handshake is pending.
        do_reset();
        in_delay = 30;
        src_req = 4'b1000;
        wait_reqin("spk_grant");
        chk("spk_busy", busy, 1);
        spike(lat);
        chk("spike_latency", lat, 1 + c_SYNC);
        spike(lat);
        spike(lat);
        chk("spk_cnt3", spike_cnt, 3);
        chk("spk_pulses3", m_spk, 3);
        chk("spk_busy_still", busy, 1);
        spike(lat);
        spike(lat);
        chk("spk_cnt5", spike_cnt, 5);
        chk("spk_saturated", d2_spike_cnt, 3);
        wait_ack(3, "spk_ack");
        src_req[3] = 1'b0;

        // Reset while waiting in RISE.
        in_delay = 30;
        @(negedge clk);
        src_req = 4'b0001;
        wait_reqin("rise_grant");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rise_req", n_req_in, 0);
        chk("rst_rise_busy", busy, 0);
        chk("rst_rise_ack", src_ack, 0);
        rst = 1'b0;
        in_delay = 2;
        wait_ack(0, "rst_rise_regrant");
        src_req[0] = 1'b0;

        // Randomized traffic on both channels.
        raises = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c % 50 == 0) in_delay = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) begin
                if (src_req[i] && src_ack[i] && $urandom_range(0, 1) == 0) begin
                    src_req[i] = 1'b0;
                end else if (!src_req[i] && $urandom_range(0, 3) == 0) begin
                    src_weight[i*8 +: 8] = 8'($urandom);
                    src_req[i] = 1'b1;
                end
            end
            if (!n_req_out && !n_ack_out && $urandom_range(0, 2) == 0) begin
                n_req_out = 1'b1;
                raises++;
            end else if (n_req_out && n_ack_out) begin
                n_req_out = 1'b0;
            end
        end
        t = 0;
        while ((src_req != 0 || busy || n_req_out || n_ack_out) && t < 1000) begin
            @(negedge clk);
            t++;
            for (int i = 0; i < 4; i++) if (src_req[i] && src_ack[i]) src_req[i] = 1'b0;
            if (n_req_out && n_ack_out) n_req_out = 1'b0;
        end
        chk("drain_done", t < 1000, 1);
        repeat (3) @(negedge clk);
        chk("rand_acks", ack_total(), grant_q.size());
        chk("rand_pulses", m_spk, raises);
        chk("rand_cnt", spike_cnt, raises);
        chk("rand_sat", d2_spike_cnt, (raises > 3) ? 3 : raises);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
